sseg_scan_ctrl: RTL
===================

# sseg_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller that takes N packed hex digits plus decimal points and drives a shared segment bus and per-digit anode enables. It is the next-generation digit multiplexer for the Pmod/board seven-segment displays. It adds the following over the fixed four-digit mux:
- built-in hex decode
- tear-free frame-synchronous input capture
- leading-zero blanking
- PWM brightness control
- configurable output polarity

It sits between the application datapath and the top-level pin remapping.

## Interface
- N_DIGITS, 4: number of multiplexed digits (2..8).
- DWELL_BITS, 18: each digit is selected for 2^DWELL_BITS cycles.
- BRIGHT_BITS, 4: brightness resolution; must be ≤ DWELL_BITS.
- ACTIVE_LOW, 1: 1 means an and sseg are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- hex  in  4*N_DIGITS  packed digit values; digit k is hex[4k+3:4k], and digit 0 is rightmost.
- dp  in  N_DIGITS  decimal point request per digit; 1 = lit.
- blank_lz  in  1  1 = enable leading-zero blanking.
- bright  in  BRIGHT_BITS  duty level; 0 = dimmest, all-ones = always on.
- an  out  N_DIGITS  digit enables, one-hot when active.
- sseg  out  8  segment bus {dp,g,f,e,d,c,b,a}, with sseg[0] = a.
- frame_tick  out  1  one-cycle pulse marking the start of each displayed frame.

## Operation
- **Counters**
  - dwell_cnt is DWELL_BITS wide and free-runs with wrap.
  - digit_idx advances when dwell_cnt is all-ones, and wraps from N_DIGITS-1 to 0.
  - One frame = N_DIGITS·2^DWELL_BITS cycles.
- **Shadow capture**
  - hex, dp and blank_lz are copied into shadow registers on the last cycle of a frame (digit_idx = N_DIGITS-1 and dwell_cnt all-ones).
  - Input changes mid-frame never appear until the next frame.
  - bright is not shadowed; it is sampled every cycle.
- **Decode** uses the standard hex font: 0–9, then A, b, C, d, E, F.
  - Internal segment value is 1 = lit.
  - Output value = lit XOR ACTIVE_LOW, applied to both an and sseg.
- **Leading-zero blanking.** When shadow blank_lz = 1:
  - Digit k ≥ 1 has segments a–g forced off if its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - The dp of a blanked digit still follows its dp bit.
- **PWM**
  - Let top = dwell_cnt[DWELL_BITS-1 -: BRIGHT_BITS].
  - The selected digit is enabled iff top ≤ bright.
  - When not enabled, all an and all sseg bits are inactive.
  - Duty is (bright+1)/2^BRIGHT_BITS.
- **Out-of-range index.** For non-power-of-two N_DIGITS, digit_idx never exceeds N_DIGITS-1; there is no dead slot.

## Timing
- **Registered outputs.** an, sseg and frame_tick are registered. They reflect the counter and shadow state of the previous cycle, giving a fixed 1-cycle latency.
- **Reset values.** While reset is high, all of the following hold; they take effect at the clock edge where reset is sampled high:
  - dwell_cnt = 0, digit_idx = 0, all shadow registers = 0.
  - an and sseg are all inactive: all-ones when ACTIVE_LOW = 1, all-zeros when ACTIVE_LOW = 0.
  - frame_tick = 0.
- **First frame after reset**
  - The first cycle after reset deasserts still shows reset values on the outputs.
  - The next cycle shows digit 0, with frame_tick = 1, using the zeroed shadow.
  - Hex input is first captured at the end of that first frame.
- **frame_tick.** High for exactly one cycle per frame, in the same cycle an first shows digit 0 with dwell 0.
- **Capture-to-display latency.** hex sampled in the capture cycle appears on the outputs 2 cycles later, together with that frame's frame_tick.
- **Reset mid-frame.** Reset aborts the scan. The next cycle's outputs are inactive and the sequence restarts exactly as after power-up; no partial-frame capture occurs.
- **bright change.** Takes effect on the output 1 cycle after it is sampled, including mid-digit.

## Test plan
Bench parameters: N_DIGITS = 4, DWELL_BITS = 4, BRIGHT_BITS = 2, ACTIVE_LOW = 1, bright = 3, unless a scenario says otherwise.

1. Reset, then hex = 16'h12AF, dp = 0, blank_lz = 0.
   - First frame: sseg = 8'hC0 (glyph "0") on all four digits.
   - Second frame: an cycles 1110 → 1101 → 1011 → 0111, 16 cycles each.
   - sseg shows F, A, 2, 1 as 8'h8E, 8'h88, 8'hA4, 8'hF9.
   - frame_tick pulses every 64 cycles.
2. hex = 16'h0040, blank_lz = 1.
   - Digits 3 and 2 have an active with sseg = 8'hFF.
   - Digit 1 shows "4" (8'h99); digit 0 shows "0" (8'hC0).
   - With hex = 0, only digit 0 shows "0".
3. Anti-tearing: change hex from 16'h1111 to 16'h2222 while digit 1 is displayed.
   - Remaining digits of that frame still show "1".
   - All digits show "2" starting at the next frame_tick.
4. PWM sweep:
   - bright = 0: an active only during dwell 0–3 of each 16-cycle slot.
   - bright = 2: dwell 0–11.
   - bright = 3: all 16 cycles.
   - sseg is 8'hFF whenever an is all-ones.
5. dp = 4'b0100 with blank_lz = 1 and hex = 0: digit 2 shows sseg = 8'h7F (dp only); other digits follow the blanking rules.
6. Reset mid-frame at digit 2:
   - Next cycle outputs an = 4'hF, sseg = 8'hFF, frame_tick = 0.
   - Sequence restarts per scenario 1.
   - Re-run 1 with ACTIVE_LOW = 0: all output bits inverted.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
//
// Time-multiplexed seven-segment display controller. N_DIGITS packed hex
// digits (plus per-digit decimal points) are scanned onto a shared segment
// bus, one digit per 2^DWELL_BITS clock cycles. The input word is captured
// into shadow registers on the last cycle of each frame, so a frame never
// mixes old and new digits. Optional leading-zero blanking, PWM brightness
// and selectable output polarity are provided.
//
// Parameters:
//   N_DIGITS    number of multiplexed digits (2..8)
//   DWELL_BITS  each digit is selected for 2^DWELL_BITS cycles
//   BRIGHT_BITS brightness resolution (<= DWELL_BITS)
//   ACTIVE_LOW  1: an/sseg are active-low, 0: active-high
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   hex         packed digits, digit k = hex[4k+3:4k], digit 0 rightmost
//   dp          decimal point request per digit, 1 = lit
//   blank_lz    1 = blank leading zeros (shadowed per frame)
//   bright      PWM duty level, sampled every cycle (not shadowed)
//   an          digit enables, one-hot when active
//   sseg        segment bus {dp,g,f,e,d,c,b,a}
//   frame_tick  one-cycle pulse when digit 0 first appears in a frame

module sseg_scan_ctrl #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned DWELL_BITS  = 18,
    parameter int unsigned BRIGHT_BITS = 4,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   hex,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    blank_lz,
    input  logic [BRIGHT_BITS-1:0]  bright,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int unsigned IDX_BITS = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_DIGITS - 1);

    // XOR masks that convert internal "1 = lit" values to pin polarity;
    // they are also the inactive (all-off) pin values.
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]          SSEG_OFF = {8{ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [DWELL_BITS-1:0] dwell_cnt;
    logic [IDX_BITS-1:0]   digit_idx;
    logic                  dwell_last;
    logic                  frame_last;

    assign dwell_last = &dwell_cnt;
    assign frame_last = dwell_last && (digit_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt <= '0;
            digit_idx <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            if (dwell_last) begin
                // Explicit wrap so non-power-of-two digit counts have no dead slot.
                digit_idx <= frame_last ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-synchronous shadow capture
    // ------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] hex_sh;
    logic [N_DIGITS-1:0]   dp_sh;
    logic                  blz_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_sh <= '0;
            dp_sh  <= '0;
            blz_sh <= 1'b0;
        end else if (frame_last) begin
            hex_sh <= hex;
            dp_sh  <= dp;
            blz_sh <= blank_lz;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking mask
    // ------------------------------------------------------------------
    // Walk from the most significant digit down: a digit is blanked while
    // it and every digit above it are zero. Digit 0 is never blanked.
    logic [N_DIGITS-1:0] blank_mask;
    logic                zero_run;

    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (hex_sh[4*k +: 4] == 4'h0);
            blank_mask[k] = blz_sh && zero_run;
        end
    end

    // ------------------------------------------------------------------
    // Current digit selection
    // ------------------------------------------------------------------
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_blank;
    logic [N_DIGITS-1:0] cur_onehot;

    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (digit_idx == IDX_BITS'(k)) begin
                cur_nibble    = hex_sh[4*k +: 4];
                cur_dp        = dp_sh[k];
                cur_blank     = blank_mask[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hex font, segments {g,f,e,d,c,b,a}, 1 = lit
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // PWM gate: the top BRIGHT_BITS of the dwell counter form a ramp that
    // is compared against bright, giving (bright+1)/2^BRIGHT_BITS duty.
    // ------------------------------------------------------------------
    logic [BRIGHT_BITS-1:0] pwm_top;
    logic                   pwm_on;

    assign pwm_top = dwell_cnt[DWELL_BITS-1 -: BRIGHT_BITS];
    assign pwm_on  = (pwm_top <= bright);

    logic [N_DIGITS-1:0] an_lit;
    logic [7:0]          sseg_lit;

    always_comb begin
        an_lit   = '0;
        sseg_lit = '0;
        if (pwm_on) begin
            an_lit   = cur_onehot;
            sseg_lit = {cur_dp, (cur_blank ? 7'h00 : hex_font(cur_nibble))};
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= AN_OFF;
            sseg       <= SSEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_lit ^ AN_OFF;
            sseg       <= sseg_lit ^ SSEG_OFF;
            frame_tick <= (digit_idx == '0) && (dwell_cnt == '0);
        end
    end

endmodule
